// File: rtl/rep_iteration_sequencer.sv
// rtl/rep_iteration_sequencer.sv - REP/REPE/REPNE iteration sequencer for the string-op engine
//
// Ports:
//   i_clk           clock
//   i_reset         synchronous, active-high reset
//   i_start         begin a sequence (sampled in IDLE only)
//   i_rep_mode      0=NONE, 1=REP, 2=REPE, 3=REPNE (latched on start)
//   i_cx_in         initial iteration count (latched on start)
//   i_irq_pending   interrupt waiting (sampled in CHECK)
//   o_iter_start    1-cycle request for one iteration
//   i_iter_done     1-cycle completion pulse from the engine
//   i_zf            zero flag, valid with i_iter_done
//   o_busy          high whenever not IDLE
//   o_done          1-cycle end-of-sequence pulse
//   o_interrupted   valid with o_done; sequence ended for an interrupt
//   o_cx_wr         CX write strobe, coincident with o_done (REP modes only)
//   o_cx_out        residual count, valid while o_cx_wr is high

module rep_iteration_sequencer #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [1:0]             i_rep_mode,
  input  logic [COUNT_WIDTH-1:0] i_cx_in,
  input  logic                   i_irq_pending,
  output logic                   o_iter_start,
  input  logic                   i_iter_done,
  input  logic                   i_zf,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_interrupted,
  output logic                   o_cx_wr,
  output logic [COUNT_WIDTH-1:0] o_cx_out
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  localparam logic [1:0] M_NONE  = 2'd0;
  localparam logic [1:0] M_REPE  = 2'd2;
  localparam logic [1:0] M_REPNE = 2'd3;

  logic [2:0]             r_state;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [1:0]             r_mode;
  logic                   r_completed;  // at least one iteration finished
  logic                   r_intr;       // CHECK chose to end for an interrupt

  logic                   w_rep;
  logic [COUNT_WIDTH-1:0] w_next_count;
  logic                   w_terminate;
  logic                   w_finish;

  assign w_rep = (r_mode != M_NONE);

  // A single (NONE) iteration leaves the count untouched. In REP modes the
  // count is nonzero in WAIT because CHECK never issues on a zero count.
  assign w_next_count = w_rep ? (r_count - COUNT_WIDTH'(1)) : r_count;

  assign w_terminate = !w_rep
                    || (w_next_count == '0)
                    || ((r_mode == M_REPE)  && !i_zf)
                    || ((r_mode == M_REPNE) &&  i_zf);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_mode      <= M_NONE;
      r_completed <= 1'b0;
      r_intr      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_count     <= i_cx_in;
            r_mode      <= i_rep_mode;
            r_completed <= 1'b0;
            r_intr      <= 1'b0;
            r_state     <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_rep && (r_count == '0)) begin
            r_state <= S_FINISH;
          end else if (i_irq_pending && r_completed) begin
            // Interrupt window opens only between iterations, never before the first.
            r_intr  <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_iter_done) begin
            r_count     <= w_next_count;
            r_completed <= 1'b1;
            r_state     <= w_terminate ? S_FINISH : S_CHECK;
          end
        end
        S_FINISH: begin
          r_intr  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_finish      = (r_state == S_FINISH);
  assign o_iter_start  = (r_state == S_ISSUE);
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = w_finish;
  assign o_interrupted = w_finish && r_intr;
  assign o_cx_wr       = w_finish && w_rep;
  assign o_cx_out      = (w_finish && w_rep) ? r_count : '0;

endmodule

// File: tb/tb_rep_iteration_sequencer.sv
// tb/tb_rep_iteration_sequencer.sv - directed table-driven bench for rep_iteration_sequencer

module tb_rep_iteration_sequencer;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic [1:0]  i_rep_mode;
  logic [15:0] i_cx_in;
  logic        i_irq_pending;
  logic        o_iter_start;
  logic        i_iter_done;
  logic        i_zf;
  logic        o_busy;
  logic        o_done;
  logic        o_interrupted;
  logic        o_cx_wr;
  logic [15:0] o_cx_out;

  int n_cmp  = 0;
  int n_fail = 0;

  rep_iteration_sequencer #(.COUNT_WIDTH(16)) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_rep_mode    (i_rep_mode),
    .i_cx_in       (i_cx_in),
    .i_irq_pending (i_irq_pending),
    .o_iter_start  (o_iter_start),
    .i_iter_done   (i_iter_done),
    .i_zf          (i_zf),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_interrupted (o_interrupted),
    .o_cx_wr       (o_cx_wr),
    .o_cx_out      (o_cx_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] cx;
    logic [7:0]  zf_pat;    // zf for the k-th iter_done is bit k
    logic        irq;
    logic        poke;      // pulse start while busy
    int          exp_iters;
    logic [15:0] exp_cx;
    logic        exp_wr;
    logic        exp_int;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_seq(input vec_t v, input int idx);
    int c, n_starts, n_dn, cd, first_c, last_c, done_c, overlap, busy_low, stray;
    logic got_done, poke_pending, got_wr, got_int;
    logic [15:0] got_cx;
    string tag;
    tag = $sformatf("v%0d", idx);
    c = 1; n_starts = 0; n_dn = 0; cd = 0; first_c = -1; last_c = -1; done_c = -1;
    overlap = 0; busy_low = 0; stray = 0;
    got_done = 1'b0; poke_pending = 1'b0; got_wr = 1'b0; got_int = 1'b0; got_cx = '0;

    i_start = 1'b1; i_rep_mode = v.mode; i_cx_in = v.cx; i_irq_pending = v.irq;
    tick();
    // Scramble the latched inputs to show they are held internally.
    i_start = 1'b0; i_rep_mode = ~v.mode; i_cx_in = ~v.cx;

    while (!got_done && c < 300) begin
      i_iter_done = 1'b0; i_zf = 1'b0; i_start = 1'b0;
      if (poke_pending) begin
        i_start = 1'b1; i_rep_mode = 2'd0; i_cx_in = 16'd9;
        poke_pending = 1'b0;
      end
      if (!o_busy) busy_low++;
      if (o_cx_wr && !o_done) stray++;
      if (o_done) begin
        got_done = 1'b1; done_c = c;
        got_cx = o_cx_out; got_wr = o_cx_wr; got_int = o_interrupted;
      end
      if (o_iter_start) begin
        if (cd > 0) overlap++;
        n_starts++;
        if (n_starts == 1) begin
          first_c = c;
          if (v.poke) poke_pending = 1'b1;
        end
        cd = 4;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          i_iter_done = 1'b1;
          i_zf = v.zf_pat[n_dn];
          n_dn++;
          last_c = c;
        end
      end
      if (!got_done) begin
        tick();
        c++;
      end
    end

    chk({tag, "_done_seen"}, 32'(got_done), 32'd1);
    chk({tag, "_iters"}, 32'(n_starts), 32'(v.exp_iters));
    chk({tag, "_cx_out"}, 32'(got_cx), 32'(v.exp_cx));
    chk({tag, "_cx_wr"}, 32'(got_wr), 32'(v.exp_wr));
    chk({tag, "_interrupted"}, 32'(got_int), 32'(v.exp_int));
    chk({tag, "_overlap"}, 32'(overlap), 32'd0);
    chk({tag, "_busy_low"}, 32'(busy_low), 32'd0);
    chk({tag, "_stray_cx_wr"}, 32'(stray), 32'd0);
    if (v.exp_iters > 0) begin
      chk({tag, "_first_iter_lat"}, 32'(first_c), 32'd2);
      chk({tag, "_done_lat"}, 32'(done_c), 32'(last_c + (v.exp_int ? 2 : 1)));
    end else begin
      chk({tag, "_zero_done_lat"}, 32'(done_c), 32'd2);
    end

    i_iter_done = 1'b0; i_zf = 1'b0; i_start = 1'b0; i_irq_pending = 1'b0;
    tick();
    chk({tag, "_idle_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_idle_done"}, 32'(o_done), 32'd0);
  endtask

  initial begin
    int act_cnt;
    i_reset = 1'b1; i_start = 1'b0; i_rep_mode = 2'd0; i_cx_in = '0;
    i_irq_pending = 1'b0; i_iter_done = 1'b0; i_zf = 1'b0;

    //            mode   cx      zf_pat   irq   poke  iters cx_out  wr    int
    vecs[0] = '{2'd1, 16'd3, 8'h00, 1'b0, 1'b0, 3, 16'd0, 1'b1, 1'b0};
    vecs[1] = '{2'd1, 16'd0, 8'h00, 1'b0, 1'b0, 0, 16'd0, 1'b1, 1'b0};
    vecs[2] = '{2'd2, 16'd5, 8'h03, 1'b0, 1'b0, 3, 16'd2, 1'b1, 1'b0};
    vecs[3] = '{2'd3, 16'd5, 8'h02, 1'b0, 1'b0, 2, 16'd3, 1'b1, 1'b0};
    vecs[4] = '{2'd1, 16'd4, 8'h00, 1'b1, 1'b0, 1, 16'd3, 1'b1, 1'b1};
    vecs[5] = '{2'd0, 16'd0, 8'h00, 1'b0, 1'b0, 1, 16'd0, 1'b0, 1'b0};
    vecs[6] = '{2'd2, 16'd3, 8'hFF, 1'b0, 1'b0, 3, 16'd0, 1'b1, 1'b0};
    vecs[7] = '{2'd3, 16'd2, 8'h00, 1'b0, 1'b0, 2, 16'd0, 1'b1, 1'b0};
    vecs[8] = '{2'd0, 16'd7, 8'h00, 1'b1, 1'b0, 1, 16'd0, 1'b0, 1'b0};
    vecs[9] = '{2'd1, 16'd2, 8'h00, 1'b0, 1'b1, 2, 16'd0, 1'b1, 1'b0};

    tick();
    tick();
    chk("reset_outputs", 32'({o_iter_start, o_busy, o_done, o_interrupted, o_cx_wr, o_cx_out}), 32'd0);
    i_reset = 1'b0;
    tick();
    chk("post_reset_idle", 32'({o_iter_start, o_busy, o_done, o_cx_wr}), 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_seq(vecs[i], i);
    end

    // Reset while waiting on the engine abandons the sequence silently.
    i_start = 1'b1; i_rep_mode = 2'd1; i_cx_in = 16'd3;
    tick();
    i_start = 1'b0;
    tick();
    chk("rst_wait_issue", 32'(o_iter_start), 32'd1);
    tick();
    chk("rst_wait_in_wait", 32'({o_busy, o_iter_start}), 32'b10);
    i_reset = 1'b1;
    tick();
    chk("rst_wait_outputs", 32'({o_iter_start, o_busy, o_done, o_interrupted, o_cx_wr, o_cx_out}), 32'd0);
    i_reset = 1'b0;
    act_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      // Stray completions while idle must be ignored.
      i_iter_done = (k % 3 == 0);
      i_zf = 1'b1;
      tick();
      if (o_done || o_cx_wr || o_iter_start || o_busy) act_cnt++;
    end
    i_iter_done = 1'b0; i_zf = 1'b0;
    chk("rst_wait_no_activity", 32'(act_cnt), 32'd0);

    // Sequence after the abandoned one must start cleanly.
    run_seq(vecs[3], 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rep_iteration_sequencer.md
Name: rep_iteration_sequencer

Overview:
- Drives a repeated string/loop operation: loads an iteration count, issues one iteration request per pass, waits for completion, decrements the count and decides termination.
- Handles the REP, REPE and REPNE termination rules and interrupt windows between iterations.
- Sits between the prefix/decode logic and the microcode string-op engine; it is the controlling end of the iteration protocol that the engine's done/next signalling answers.
- Writes the residual count back to the CX register when it finishes.

Parameters:
- COUNT_WIDTH, 16, width of the iteration count and the CX write-back value.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a sequence; sampled only in IDLE
- rep_mode  in  2  0=NONE (single iteration), 1=REP, 2=REPE, 3=REPNE; latched on start
- cx_in  in  COUNT_WIDTH  initial count; latched on start
- irq_pending  in  1  interrupt waiting; sampled in CHECK
- iter_start  out  1  1-cycle pulse requesting one iteration
- iter_done  in  1  1-cycle pulse from the engine, iteration complete
- zf  in  1  zero flag from the iteration; valid in the iter_done cycle
- busy  out  1  high in any state other than IDLE
- done  out  1  1-cycle pulse when the sequence ends
- interrupted  out  1  valid with done; 1 = ended early for an interrupt
- cx_wr  out  1  1-cycle CX write strobe, coincident with done
- cx_out  out  COUNT_WIDTH  residual count, valid while cx_wr is high

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset value of every output: all outputs 0. State goes to IDLE, and the count and mode registers clear.
- Reset mid-sequence abandons the sequence with no done and no cx_wr.
- States:
  - IDLE: when start=1, latch cx_in into count, latch rep_mode and clear the first flag, then go to CHECK. start is ignored in every other state.
  - CHECK (1 cycle), priority order:
    1. mode!=NONE and count==0 -> FINISH, no iteration issued.
    2. irq_pending=1 and at least one iteration already completed -> FINISH with interrupted=1. No interrupt is taken before the first iteration.
    3. Otherwise -> ISSUE.
  - ISSUE (1 cycle): iter_start=1, then go to WAIT.
  - WAIT: hold until iter_done=1. In that cycle:
    - if mode!=NONE, count <= count-1;
    - set the "an iteration has completed" flag;
    - evaluate termination using the decremented count (next_count) and zf.
  - Termination in WAIT, any one true -> FINISH, otherwise -> CHECK:
    - mode==NONE;
    - next_count==0;
    - mode==REPE and zf==0;
    - mode==REPNE and zf==1.
  - FINISH (1 cycle): done=1. cx_wr=1 and cx_out=count only if mode!=NONE. interrupted as decided in CHECK, otherwise 0. Then go to IDLE.
- Latency:
  - start in cycle T -> CHECK T+1 -> iter_start T+2.
  - iter_done in cycle N (non-terminal) -> CHECK N+1 -> iter_start N+2.
  - Terminal iter_done in N -> done/cx_wr in N+1.
  - Zero count: start in T -> done in T+2.
- Arithmetic: unsigned decrement. Count never wraps, because a zero count never issues an iteration.
- cx_in = all ones gives 2^COUNT_WIDTH-1 iterations.
- iter_done outside WAIT is ignored, and so is zf outside the iter_done cycle.
- rep_mode is held constant for the whole sequence; changes on the input after start have no effect.
- iter_start is never asserted twice without an intervening iter_done.

Test Plan:
1. REP, cx_in=3, iter_done 4 cycles after each iter_start, zf=X -> exactly 3 iter_start pulses; then done=1, cx_wr=1, cx_out=0, interrupted=0 one cycle after the third iter_done.
2. REP, cx_in=0 -> no iter_start; done and cx_wr in cycle T+2 with cx_out=0; busy high for 2 cycles.
3. REPE, cx_in=5, zf=1,1,0 on successive iter_done -> 3 iterations; done with cx_out=2.
4. REPNE, cx_in=5, zf=0 then 1 -> 2 iterations, cx_out=3.
5. REP, cx_in=4, irq_pending asserted from start -> first iteration still issued; next CHECK ends the sequence with done=1, interrupted=1, cx_out=3.
6. Robustness cases:
   - NONE, cx_in=0 -> one iteration issued, then done=1 with cx_wr=0.
   - REP with reset asserted in WAIT -> all outputs 0 the next cycle, no done pulse.
   - start pulsed while busy -> ignored.
